// File: rtl/xillybus_bridge_pkg.sv
// Shared types and width helpers for the multi-channel Xillybus loopback bridge.
package xillybus_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        EOF    = 2'd3
    } chan_state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Level must be able to hold DEPTH itself, hence the +1.
    function automatic int level_width(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/xillybus_chan_fifo.sv
// One write->read channel: FIFO storage, occupancy and flags, plus the
// open/close state machine that produces EOF and flush-on-close.
module xillybus_chan_fifo
    import xillybus_bridge_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 512,
    localparam int AW   = clog2(DEPTH),
    localparam int LW   = level_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          quiesce,
    input  logic          w_open,
    input  logic          wren,
    input  logic [DW-1:0] wdata,
    output logic          full,
    input  logic          r_open,
    input  logic          rden,
    output logic [DW-1:0] rdata,
    output logic          empty,
    output logic          eof,
    output logic [LW-1:0] level,
    output logic          ovf
);

    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_next;
    logic          w_open_q;
    logic          r_open_q;
    logic          flush;
    logic          wr_acc;
    logic          rd_acc;
    logic          eof_next;
    chan_state_t   state;
    chan_state_t   state_next;

    // Quiesce flushes unconditionally; a read-side close flushes only once the writer is gone.
    assign flush  = quiesce | (r_open_q & ~r_open & ~w_open);
    assign wr_acc = wren & ~full & ~flush;
    assign rd_acc = rden & ~empty & ~flush;

    always_comb begin
        level_next = level;
        if (wr_acc && !rd_acc) begin
            level_next = level + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            level_next = level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level_next;
            full  <= (level_next == LEVEL_FULL);
            empty <= (level_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_acc) begin
            rdata <= mem[rd_ptr];
        end
    end

    // A write attempt against a full FIFO is lost even if a read frees a slot in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || quiesce) begin
            ovf <= 1'b0;
        end else if (wren && full) begin
            ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_open_q <= 1'b0;
            r_open_q <= 1'b0;
        end else begin
            w_open_q <= w_open;
            r_open_q <= r_open;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (w_open && !w_open_q) begin
                        state_next = STREAM;
                    end
                end
                STREAM: begin
                    if (!w_open) begin
                        state_next = (level != '0) ? DRAIN : EOF;
                    end
                end
                DRAIN: begin
                    if (w_open) begin
                        state_next = STREAM;
                    end else if (level == '0) begin
                        state_next = EOF;
                    end
                end
                EOF: begin
                    if (w_open) begin
                        state_next = STREAM;
                    end else if (!r_open) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        eof_next = (state_next == EOF) && r_open;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eof <= 1'b0;
        end else begin
            eof <= eof_next;
        end
    end

endmodule

// File: rtl/xillybus_loopback_bridge.sv
// Multi-channel loopback bridge: one independent xillybus_chan_fifo per
// channel, with the flat Xillybus port vectors sliced per channel.
module xillybus_loopback_bridge
    import xillybus_bridge_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DW     = 32,
    parameter int DEPTH  = 512,
    localparam int LW    = level_width(DEPTH)
) (
    input  logic                 bus_clk_w,
    input  logic                 bus_rst_w,
    input  logic                 quiesce_w,
    input  logic [NUM_CH-1:0]    user_w_open_w,
    input  logic [NUM_CH-1:0]    user_w_wren_w,
    input  logic [NUM_CH*DW-1:0] user_w_data_w,
    output logic [NUM_CH-1:0]    user_w_full_w,
    input  logic [NUM_CH-1:0]    user_r_open_w,
    input  logic [NUM_CH-1:0]    user_r_rden_w,
    output logic [NUM_CH*DW-1:0] user_r_data_w,
    output logic [NUM_CH-1:0]    user_r_empty_w,
    output logic [NUM_CH-1:0]    user_r_eof_w,
    output logic [NUM_CH*LW-1:0] chan_level_w,
    output logic [NUM_CH-1:0]    chan_ovf_w
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        xillybus_chan_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_chan (
            .clk     (bus_clk_w),
            .rst     (bus_rst_w),
            .quiesce (quiesce_w),
            .w_open  (user_w_open_w[c]),
            .wren    (user_w_wren_w[c]),
            .wdata   (user_w_data_w[c*DW +: DW]),
            .full    (user_w_full_w[c]),
            .r_open  (user_r_open_w[c]),
            .rden    (user_r_rden_w[c]),
            .rdata   (user_r_data_w[c*DW +: DW]),
            .empty   (user_r_empty_w[c]),
            .eof     (user_r_eof_w[c]),
            .level   (chan_level_w[c*LW +: LW]),
            .ovf     (chan_ovf_w[c])
        );
    end

endmodule

// File: tb/tb_xillybus_loopback_bridge.sv
// Scoreboard bench for xillybus_loopback_bridge: a queue-based channel model
// predicts read data and flags; a monitor compares every cycle.
module tb_xillybus_loopback_bridge;

    localparam int NUM_CH = 4;
    localparam int DW     = 16;
    localparam int DEPTH  = 8;
    localparam int LW     = 4;

    localparam int M_IDLE   = 0;
    localparam int M_STREAM = 1;
    localparam int M_DRAIN  = 2;
    localparam int M_EOF    = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 quiesce = 1'b0;
    logic [NUM_CH-1:0]    w_open = '0;
    logic [NUM_CH-1:0]    wren = '0;
    logic [NUM_CH*DW-1:0] wdata = '0;
    logic [NUM_CH-1:0]    full;
    logic [NUM_CH-1:0]    r_open = '0;
    logic [NUM_CH-1:0]    rden = '0;
    logic [NUM_CH*DW-1:0] rdata;
    logic [NUM_CH-1:0]    empty;
    logic [NUM_CH-1:0]    eof;
    logic [NUM_CH*LW-1:0] level;
    logic [NUM_CH-1:0]    ovf;

    logic [DW-1:0] mq [NUM_CH][$];
    logic [DW-1:0] exp_q [NUM_CH][$];
    logic [DW-1:0] last_data [NUM_CH];
    int            m_state [NUM_CH];
    bit            m_ovf [NUM_CH];
    bit            m_eof [NUM_CH];
    bit            m_pw [NUM_CH];
    bit            m_pr [NUM_CH];

    bit checking = 1'b0;
    int n_checks = 0;
    int n_pass   = 0;

    xillybus_loopback_bridge #(
        .NUM_CH (NUM_CH),
        .DW     (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .bus_clk_w      (clk),
        .bus_rst_w      (rst),
        .quiesce_w      (quiesce),
        .user_w_open_w  (w_open),
        .user_w_wren_w  (wren),
        .user_w_data_w  (wdata),
        .user_w_full_w  (full),
        .user_r_open_w  (r_open),
        .user_r_rden_w  (rden),
        .user_r_data_w  (rdata),
        .user_r_empty_w (empty),
        .user_r_eof_w   (eof),
        .chan_level_w   (level),
        .chan_ovf_w     (ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int ch,
                               input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s ch%0d: got %0h expected %0h at %0t",
                     name, ch, actual, expected, $time);
        end
    endtask

    // Channel behaviour from the rules: queue contents are the FIFO, a read
    // pushes the word it returns into the scoreboard.
    task automatic model_step(input int c);
        int            sz;
        int            ns;
        bit            w, r, we, re, fl;
        logic [DW-1:0] d;
        w  = w_open[c];
        r  = r_open[c];
        we = wren[c];
        re = rden[c];
        d  = wdata[c*DW +: DW];
        sz = mq[c].size();
        if (rst) begin
            mq[c].delete();
            exp_q[c].delete();
            exp_q[c].push_back('0);
            m_state[c] = M_IDLE;
            m_ovf[c]   = 1'b0;
            m_eof[c]   = 1'b0;
            m_pw[c]    = 1'b0;
            m_pr[c]    = 1'b0;
        end else begin
            if (quiesce) begin
                mq[c].delete();
                m_ovf[c]   = 1'b0;
                m_state[c] = M_IDLE;
            end else begin
                fl = m_pr[c] && !r && !w;
                if (we && sz == DEPTH) m_ovf[c] = 1'b1;
                ns = m_state[c];
                if (fl) begin
                    mq[c].delete();
                    ns = M_IDLE;
                end else begin
                    if (re && sz > 0) exp_q[c].push_back(mq[c].pop_front());
                    if (we && sz < DEPTH) mq[c].push_back(d);
                    case (m_state[c])
                        M_IDLE:   if (w && !m_pw[c]) ns = M_STREAM;
                        M_STREAM: if (!w) ns = (sz != 0) ? M_DRAIN : M_EOF;
                        M_DRAIN:  if (w) ns = M_STREAM; else if (sz == 0) ns = M_EOF;
                        default:  if (w) ns = M_STREAM; else if (!r) ns = M_IDLE;
                    endcase
                end
                m_state[c] = ns;
            end
            m_eof[c] = (m_state[c] == M_EOF) && r;
            m_pw[c]  = w;
            m_pr[c]  = r;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            for (int c = 0; c < NUM_CH; c++) model_step(c);
        end
    end

    // Monitor: pops a scoreboard entry when a read result is due, otherwise
    // expects the previous read data to be held.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (checking) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (exp_q[c].size() != 0) last_data[c] = exp_q[c].pop_front();
                    checkOutput("rdata", c, 32'(rdata[c*DW +: DW]), 32'(last_data[c]));
                    checkOutput("level", c, 32'(level[c*LW +: LW]), 32'(mq[c].size()));
                    checkOutput("empty", c, 32'(empty[c]), 32'(mq[c].size() == 0));
                    checkOutput("full",  c, 32'(full[c]),  32'(mq[c].size() == DEPTH));
                    checkOutput("ovf",   c, 32'(ovf[c]),   32'(m_ovf[c]));
                    checkOutput("eof",   c, 32'(eof[c]),   32'(m_eof[c]));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input int c, input bit we, input logic [DW-1:0] d, input bit re);
        wren[c]             = we;
        rden[c]             = re;
        wdata[c*DW +: DW]   = d;
        @(negedge clk);
        wren[c]             = 1'b0;
        rden[c]             = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        checking = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Basic write then read on ch0; ch2 holds two words throughout.
        w_open[0] = 1'b1;
        r_open[0] = 1'b1;
        w_open[2] = 1'b1;
        applyStimulus(2, 1'b1, 16'h0055, 1'b0);
        applyStimulus(2, 1'b1, 16'h0066, 1'b0);
        applyStimulus(0, 1'b1, 16'h00A1, 1'b0);
        applyStimulus(0, 1'b1, 16'h00A2, 1'b0);
        applyStimulus(0, 1'b1, 16'h00A3, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, '0, 1'b1);
        tick(2);

        // Overfill ch3 then drain it completely.
        w_open[3] = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(3, 1'b1, 16'h3000 + 16'(i), 1'b0);
        r_open[3] = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(3, 1'b0, '0, 1'b1);
        tick(2);

        // Close the writer with data pending, drain, then close the reader.
        applyStimulus(0, 1'b1, 16'h0B01, 1'b0);
        applyStimulus(0, 1'b1, 16'h0B02, 1'b0);
        w_open[0] = 1'b0;
        tick(2);
        applyStimulus(0, 1'b0, '0, 1'b1);
        applyStimulus(0, 1'b0, '0, 1'b1);
        tick(3);
        r_open[0] = 1'b0;
        tick(2);

        // Full ch1 with a simultaneous write and read.
        w_open[1] = 1'b1;
        r_open[1] = 1'b1;
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 1'b1, 16'h1000 + 16'(i), 1'b0);
        applyStimulus(1, 1'b1, 16'h1EEE, 1'b1);
        tick(1);

        // Flush-on-close of buffered data on ch0, then reopen.
        w_open[0] = 1'b1;
        r_open[0] = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 16'h0C00 + 16'(i), 1'b0);
        w_open[0] = 1'b0;
        tick(1);
        r_open[0] = 1'b0;
        tick(2);
        r_open[0] = 1'b1;
        tick(2);
        applyStimulus(0, 1'b0, '0, 1'b1);
        tick(1);

        // Bring ch1 to level 5, then quiesce everything.
        applyStimulus(1, 1'b0, '0, 1'b1);
        applyStimulus(1, 1'b0, '0, 1'b1);
        quiesce = 1'b1;
        tick(1);
        quiesce = 1'b0;
        tick(3);

        // Randomised traffic on all channels.
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 29) == 0) w_open[c] = ~w_open[c];
                if ($urandom_range(0, 29) == 0) r_open[c] = ~r_open[c];
                wren[c]           = ($urandom_range(0, 1) == 1);
                rden[c]           = ($urandom_range(0, 2) == 0);
                wdata[c*DW +: DW] = DW'($urandom);
            end
            quiesce = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        wren    = '0;
        rden    = '0;
        quiesce = 1'b0;
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
